// File: rtl/e_mdu_ctrl_pkg.sv
// rtl/e_mdu_ctrl_pkg.sv - MDU op encodings, FSM state codes and op-class helpers
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_mul(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_muldiv(input mdu_op_e op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// rtl/e_mdu_ctrl_if.sv - E-stage to MDU controller signal bundle
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  logic        start;
  mdu_op_e     mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_out;

  modport master (
    output start, mdu_op, rs_val, rt_val, d_is_md,
    input  busy, stall_req, hi, lo, rd_out
  );

  modport slave (
    input  start, mdu_op, rs_val, rt_val, d_is_md,
    output busy, stall_req, hi, lo, rd_out
  );

endinterface

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - multi-cycle MULT/DIV sequencer owning HI/LO, with D-stage stall request
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  e_mdu_ctrl_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_op_e           op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              signed_op;
  logic              a_neg, b_neg;
  logic [31:0]       num, den;
  logic [31:0]       quo, rem;
  logic [63:0]       prod;
  logic [31:0]       res_hi, res_lo;

  // Signed divide works on magnitudes; 0x80000000 is its own magnitude, so
  // 0x80000000 / -1 naturally yields lo=0x80000000, hi=0.
  always_comb begin
    signed_op = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    a_neg     = signed_op && a_q[31];
    b_neg     = signed_op && b_q[31];
    num       = a_neg ? -a_q : a_q;
    den       = b_neg ? -b_q : b_q;
    if (den == 32'd0) begin
      den = 32'd1;
    end
    quo    = num / den;
    rem    = num % den;
    prod   = 64'd0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      MDU_MULT: begin
        prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        {res_hi, res_lo} = prod;
      end
      MDU_MULTU: begin
        prod = {32'd0, a_q} * {32'd0, b_q};
        {res_hi, res_lo} = prod;
      end
      MDU_DIV, MDU_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_neg ^ b_neg) ? -quo : quo;
          res_hi = a_neg ? -rem : rem;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu.start) begin
          case (mdu.mdu_op)
            MDU_MULT, MDU_MULTU: begin
              op_d    = mdu.mdu_op;
              a_d     = mdu.rs_val;
              b_d     = mdu.rt_val;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              op_d    = mdu.mdu_op;
              a_d     = mdu.rs_val;
              b_d     = mdu.rt_val;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_DIV;
            end
            MDU_MTHI: hi_d = mdu.rs_val;
            MDU_MTLO: lo_d = mdu.rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // A start arriving here is dropped; the D-stage stall keeps it from happening.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.busy      = (state_q != ST_IDLE);
  assign mdu.stall_req = mdu.d_is_md & (mdu.busy | (mdu.start & is_muldiv(mdu.mdu_op)));
  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;
  assign mdu.rd_out    = (mdu.mdu_op == MDU_MFHI) ? hi_q :
                         (mdu.mdu_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule
